// File: rtl/quad_decoder_pkg.sv
// quad_pkg: shared FSM state, phase encodings and forward-order helper for the quadrature decoder.
package quad_pkg;

    typedef enum logic {INIT, TRACK} state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    // Forward (up) order is 00 -> 01 -> 11 -> 10 -> 00, phase vector is {A,B}
    function automatic logic [1:0] next_phase(input logic [1:0] phase);
        return phase == PH_00 ? PH_01 :
               phase == PH_01 ? PH_11 :
               phase == PH_11 ? PH_10 : PH_00;
    endfunction

endpackage

// File: rtl/quad_sync_filter.sv
// quad_sync_filter: synchronizes the {A,B} pair and accepts a new phase only after
// FILTER_LEN consecutive identical samples; acc pulses the cycle after an accept.
module quad_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] raw,
    output logic [1:0] phase,
    output logic       acc
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0][1:0] sync;
    logic [1:0]                  s, prev;
    logic [CW-1:0]               cnt, seen;
    logic                        load;

    // seen is the run length of the current sample, including this cycle
    always_comb begin
        s    = sync[SYNC_STAGES-1];
        seen = s == prev ? cnt + CW'(1) : CW'(1);
        load = s != phase && seen >= CW'(FILTER_LEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            prev  <= 2'b00;
            cnt   <= '0;
            phase <= 2'b00;
            acc   <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            prev <= s;
            cnt  <= (s != phase && !load) ? seen : '0;
            if (load) phase <= s;
            acc  <= load;
        end
    end

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: x4 quadrature decoder producing step/direction pulses, a wrapping
// position count and a sticky flag for illegal double-edge transitions.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             en,
    input  logic             clr,
    input  logic             err_clr,
    output logic             step,
    output logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             err
);
    logic [1:0] phase, last;
    logic       acc, fwd, bwd, track, move, bad;
    state_t     state;

    quad_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_filt (
        .clk  (clk),
        .rst_n(rst_n),
        .raw  ({a_in, b_in}),
        .phase(phase),
        .acc  (acc)
    );

    // An accepted phase always differs from last, so neither neighbour means both bits flipped
    always_comb begin
        fwd   = phase == next_phase(last);
        bwd   = last == next_phase(phase);
        track = acc && state == TRACK;
        move  = track && en && (fwd || bwd);
        bad   = track && !fwd && !bwd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            last    <= PH_00;
            step    <= 1'b0;
            up_down <= 1'b1;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            if (acc) begin
                state <= TRACK;
                last  <= phase;
            end
            step <= move;
            if (move) up_down <= fwd;
            count <= clr ? '0 : move ? (fwd ? count + WIDTH'(1) : count - WIDTH'(1)) : count;
            err   <= bad || (err && !err_clr);
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: randomized scoreboard bench; a phase-level reference model queues
// expected output events and a monitor matches them against the DUT.
module tb_quad_decoder;

    typedef struct {
        int         cyc;
        logic       step;
        logic       ud;
        logic [7:0] cnt;
        logic       e;
    } rec_t;

    logic       clk = 1'b0, rst_n = 1'b0, a_in = 1'b0, b_in = 1'b0;
    logic       en = 1'b1, clr = 1'b0, err_clr = 1'b0;
    logic       step, up_down, err;
    logic [7:0] count;

    quad_decoder #(.WIDTH(8), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_in   (a_in),
        .b_in   (b_in),
        .en     (en),
        .clr    (clr),
        .err_clr(err_clr),
        .step   (step),
        .up_down(up_down),
        .count  (count),
        .err    (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rec_t       q[$];
    int         compared = 0, mismatched = 0;
    bit         mute = 1'b1;
    logic [1:0] cur, m_filt;
    bit         m_init;
    logic [7:0] m_cnt;
    logic       m_ud, m_err;

    function automatic int pos(input logic [1:0] p);
        return p == 2'b00 ? 0 : p == 2'b01 ? 1 : p == 2'b11 ? 2 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_filt = 2'b00;
        m_init = 1'b1;
        m_cnt  = 8'h00;
        m_ud   = 1'b1;
        m_err  = 1'b0;
    endtask

    // Drive a level and hold it; optionally assert clr / err_clr in the cycle the outputs update
    task automatic phase(input logic [1:0] lvl, input int hold, input bit clr_at = 0, input bit ec_at = 0);
        int k, d;
        k = cyc + 1;
        {a_in, b_in} = lvl;
        cur = lvl;
        if (lvl != m_filt) begin
            if (m_init) m_init = 1'b0;
            else begin
                d = (pos(lvl) - pos(m_filt) + 4) % 4;
                if (d == 2) begin
                    if (!m_err) begin
                        m_err = 1'b1;
                        q.push_back('{k + 5, 1'b0, m_ud, m_cnt, 1'b1});
                    end
                end else if (en) begin
                    m_ud  = d == 1;
                    m_cnt = clr_at ? 8'h00 : d == 1 ? m_cnt + 8'd1 : m_cnt - 8'd1;
                    q.push_back('{k + 5, 1'b1, m_ud, m_cnt, m_err});
                end
            end
            m_filt = lvl;
        end
        if (clr_at || ec_at) begin
            tick(5);
            clr     = clr_at;
            err_clr = ec_at;
            tick(1);
            clr     = 1'b0;
            err_clr = 1'b0;
            tick(hold - 6);
        end else tick(hold);
    endtask

    task automatic glitch(input int g);
        {a_in, b_in} = cur ^ 2'($urandom_range(1, 3));
        tick(g);
        {a_in, b_in} = cur;
        tick(8);
    endtask

    task automatic pulse_clr();
        tick(7);
        clr = 1'b1;
        if (m_cnt != 8'h00) begin
            m_cnt = 8'h00;
            q.push_back('{cyc + 1, 1'b0, m_ud, 8'h00, m_err});
        end
        tick(1);
        clr = 1'b0;
    endtask

    task automatic pulse_err_clr();
        tick(7);
        err_clr = 1'b1;
        if (m_err) begin
            m_err = 1'b0;
            q.push_back('{cyc + 1, 1'b0, m_ud, m_cnt, 1'b0});
        end
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic set_en(input logic v);
        tick(7);
        en = v;
    endtask

    // Monitor: any step, err change or count change is an output event to match
    logic       l_err;
    logic [7:0] l_cnt;
    always @(posedge clk) begin
        rec_t r;
        #1;
        if (mute) begin
            l_err = err;
            l_cnt = count;
        end else if (step || err !== l_err || count !== l_cnt) begin
            compared++;
            if (q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_event: cyc=%0d step=%b ud=%b count=%0d err=%b, none queued",
                         cyc, step, up_down, count, err);
            end else begin
                r = q.pop_front();
                if (r.cyc != cyc || r.step !== step || r.ud !== up_down || r.cnt !== count || r.e !== err) begin
                    mismatched++;
                    $display("FAIL event: got cyc=%0d step=%b ud=%b count=%0d err=%b want cyc=%0d step=%b ud=%b count=%0d err=%b",
                             cyc, step, up_down, count, err, r.cyc, r.step, r.ud, r.cnt, r.e);
                end
            end
            l_err = err;
            l_cnt = count;
        end
    end

    initial begin
        logic [1:0] fwd_seq [4];
        fwd_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        model_reset();
        {a_in, b_in} = 2'b11;
        #12;
        chk("reset_step", step, 0);
        chk("reset_up_down", up_down, 1);
        chk("reset_count", count, 0);
        chk("reset_err", err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        mute = 1'b0;
        phase(2'b11, 20);
        chk("init_no_step_count", count, 0);
        chk("init_no_err", err, 0);
        phase(2'b10, 10);
        phase(2'b00, 10);
        pulse_clr();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++) phase(fwd_seq[i], 10);
        chk("fwd_count_8", count, 8);
        pulse_clr();
        phase(2'b10, 10);
        chk("wrap_down_ff", count, 8'hFF);
        chk("wrap_down_dir", up_down, 0);
        phase(2'b00, 10);
        chk("wrap_up_zero", count, 0);
        glitch(2);
        chk("glitch_ignored", count, 0);
        phase(2'b10, 10);
        chk("held_edge_counts", count, 8'hFF);
        phase(2'b00, 10);
        phase(2'b11, 10);
        chk("illegal_sets_err", err, 1);
        pulse_err_clr();
        chk("err_clr_clears", err, 0);
        phase(2'b00, 10, 0, 1);
        chk("illegal_beats_err_clr", err, 1);
        phase(2'b11, 10, 0, 1);
        pulse_err_clr();
        phase(2'b10, 10);
        phase(2'b00, 10);
        set_en(1'b0);
        phase(2'b01, 10);
        phase(2'b11, 10);
        phase(2'b10, 10);
        chk("en_low_holds", count, 2);
        set_en(1'b1);
        phase(2'b00, 12, 1, 0);
        chk("clr_beats_step", count, 0);
        phase(2'b10, 10);
        phase(2'b01, 10);
        tick(7);
        chk("queue_drained_pre_reset", q.size(), 0);
        mute = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_step", step, 0);
        chk("async_rst_up_down", up_down, 1);
        chk("async_rst_count", count, 0);
        chk("async_rst_err", err, 0);
        q.delete();
        model_reset();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        mute = 1'b0;
        phase(cur, 8);
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: glitch($urandom_range(1, 2));
                1: pulse_clr();
                2: pulse_err_clr();
                3: set_en(1'($urandom_range(0, 3) != 0));
                default: phase(2'($urandom), $urandom_range(4, 10));
            endcase
        end
        tick(12);
        chk("final_queue_empty", q.size(), 0);
        chk("final_count", count, m_cnt);
        chk("final_err", err, m_err);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
